// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment bank.
// It has one shared segment decoder and a double-buffered display word that is swapped only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned NDIG  = 8,
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   load_dp,
  output logic [NDIG-1:0]   an_n,
  output logic [6:0]        seg,
  output logic              dp_n,
  output logic              frame_tick
);

  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic [4*NDIG-1:0]   disp_d;
  logic [NDIG-1:0]     disp_p;
  logic [4*NDIG-1:0]   pend_d;
  logic [NDIG-1:0]     pend_p;
  logic                pend_v;
  logic                armed;
  logic                at_frame;
  logic                commit;
  logic                accept;
  logic [3:0]          cur_d;
  logic                cur_p;

  // Active-low segment pattern {g..a} for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  assign at_frame = (state == S_BLANK) && (idx == '0) && (cnt == '0);
  assign commit   = en && at_frame;
  assign accept   = load_valid && !pend_v;

  // The armed flag suppresses the tick on the first commit cycle after a reset or a re-enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_BLANK;
      idx    <= '0;
      cnt    <= '0;
      disp_d <= '0;
      disp_p <= '0;
      pend_d <= '0;
      pend_p <= '0;
      pend_v <= 1'b0;
      armed  <= 1'b0;
    end else begin
      if (!en) begin
        state <= S_BLANK;
        idx   <= '0;
        cnt   <= '0;
        armed <= 1'b0;
      end else begin
        armed <= 1'b1;
        if (cnt == CW'(DIV - 1)) begin
          cnt   <= '0;
          state <= S_BLANK;
          idx   <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        end else begin
          cnt <= cnt + CW'(1);
          if (state == S_BLANK && cnt == CW'(BLANK - 1)) state <= S_SHOW;
        end
      end
      // accept needs !pend_v and a swap needs pend_v, so the two never act on the same cycle
      if (accept) begin
        pend_d <= load_data;
        pend_p <= load_dp;
        pend_v <= 1'b1;
      end else if (commit && pend_v) begin
        disp_d <= pend_d;
        disp_p <= pend_p;
        pend_v <= 1'b0;
      end
    end
  end

  // Digit drive is decoded from the registered scan position; en gates it immediately
  always_comb begin
    cur_d      = '0;
    cur_p      = 1'b0;
    an_n       = '1;
    seg        = 7'h7F;
    dp_n       = 1'b1;
    load_ready = !pend_v;
    frame_tick = commit && armed;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idx == IW'(i)) begin
        cur_d = disp_d[4*i +: 4];
        cur_p = disp_p[i];
        if (en && state == S_SHOW) an_n[i] = 1'b0;
      end
    end
    if (en && state == S_SHOW) begin
      seg  = hex7(cur_d);
      dp_n = !cur_p;
    end
  end

endmodule
